// File: rtl/alarm_delay_ctrl_pkg.sv
// alarm_pkg: shared definitions for the alarm delay controller.
//   STATE_W          width of the state encoding
//   ST_*             state encodings (codes 5..7 are unused and recover to DISARMED)
//   DEF_*            default delay values and counter width
//   isTimed()        true for states that run the seconds counter
package alarm_pkg;

  localparam int STATE_W = 3;

  typedef logic [STATE_W-1:0] stateT;

  localparam stateT ST_DISARMED    = 3'd0;
  localparam stateT ST_EXIT_DELAY  = 3'd1;
  localparam stateT ST_ARMED       = 3'd2;
  localparam stateT ST_ENTRY_DELAY = 3'd3;
  localparam stateT ST_ALARM       = 3'd4;

  localparam int DEF_EXIT_SEC  = 30;
  localparam int DEF_ENTRY_SEC = 15;
  localparam int DEF_SIREN_SEC = 180;
  localparam int DEF_CNT_W     = 8;

  // Timed states keep the upstream timer running and count secLeft down.
  function automatic logic isTimed(input stateT s);
    logic timed;
    case (s)
      ST_EXIT_DELAY:  timed = 1'b1;
      ST_ENTRY_DELAY: timed = 1'b1;
      ST_ALARM:       timed = 1'b1;
      default:        timed = 1'b0;
    endcase
    return timed;
  endfunction

endpackage

// File: rtl/alarm_delay_ctrl_if.sv
// alarm_delay_ctrl_if: keypad/sensor/timer signals of the alarm delay controller.
//   Inputs to the controller : tick, armReq, disarmReq, delayedZone, instantZone
//   Outputs of the controller: tmrEN, armed, siren, beep, secLeft, stateOut
//   master modport: the environment driving sensors/keypad/timer tick
//   slave  modport: the controller itself
interface alarm_delay_ctrl_if
  import alarm_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);

  logic             tick;
  logic             armReq;
  logic             disarmReq;
  logic             delayedZone;
  logic             instantZone;
  logic             tmrEN;
  logic             armed;
  logic             siren;
  logic             beep;
  logic [CNT_W-1:0] secLeft;
  stateT            stateOut;

  modport master (
    output tick, armReq, disarmReq, delayedZone, instantZone,
    input  tmrEN, armed, siren, beep, secLeft, stateOut
  );

  modport slave (
    input  tick, armReq, disarmReq, delayedZone, instantZone,
    output tmrEN, armed, siren, beep, secLeft, stateOut
  );

endinterface

// File: rtl/alarm_delay_ctrl_sec_down_counter.sv
// sec_down_counter: loadable seconds down-counter.
//   clkSignal, RST : clock, asynchronous active-high reset
//   load, loadVal  : synchronous load (wins over dec)
//   dec            : decrement by one (accepted tick); saturates at zero
//   count          : registered counter value
//   isOne          : count == 1, the next accepted tick is the last second
module sec_down_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clkSignal,
  input  logic             RST,
  input  logic             load,
  input  logic [CNT_W-1:0] loadVal,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             isOne
);

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  // Counter register: load has priority, then decrement.
  always_ff @(posedge clkSignal or posedge RST) begin
    if (RST) begin
      count <= CNT_ZERO;
    end else if (load) begin
      count <= loadVal;
    end else if (dec && (count != CNT_ZERO)) begin
      count <= count - CNT_ONE;
    end else begin
      count <= count;
    end
  end

  assign isOne = (count == CNT_ONE);

endmodule

// File: rtl/alarm_delay_ctrl.sv
// alarm_delay_ctrl: arming / exit-delay / entry-delay / siren controller.
//   clkSignal, RST : clock, asynchronous active-high reset
//   bus (slave)    : tick, armReq, disarmReq, delayedZone, instantZone in;
//                    tmrEN, armed, siren, beep, secLeft, stateOut out.
// All outputs are registered and describe the state entered on the same edge.
module alarm_delay_ctrl
  import alarm_pkg::*;
#(
  parameter int EXIT_SEC  = DEF_EXIT_SEC,
  parameter int ENTRY_SEC = DEF_ENTRY_SEC,
  parameter int SIREN_SEC = DEF_SIREN_SEC,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic         clkSignal,
  input  logic         RST,
  alarm_delay_ctrl_if.slave bus
);

  stateT            stateR;
  stateT            nextStateS;
  logic             tmrENR;
  logic             armedR;
  logic             sirenR;
  logic             beepR;
  logic             tmrENNextS;
  logic             armedNextS;
  logic             sirenNextS;
  logic             beepNextS;
  logic             loadS;
  logic [CNT_W-1:0] loadValS;
  logic             accTickS;
  logic             expireS;
  logic             stateChangeS;
  logic             countingS;
  logic [CNT_W-1:0] secCountS;
  logic             isOneS;

  // A tick only counts while the upstream timer is enabled.
  assign accTickS = bus.tick & tmrENR;
  assign expireS  = accTickS & isOneS;

  sec_down_counter #(
    .CNT_W (CNT_W)
  ) uCounter (
    .clkSignal (clkSignal),
    .RST       (RST),
    .load      (loadS),
    .loadVal   (loadValS),
    .dec       (accTickS),
    .count     (secCountS),
    .isOne     (isOneS)
  );

  // State register.
  always_ff @(posedge clkSignal or posedge RST) begin
    if (RST) begin
      stateR <= ST_DISARMED;
    end else begin
      stateR <= nextStateS;
    end
  end

  // Next-state logic; disarm overrides everything.
  always_comb begin
    nextStateS = stateR;
    if (bus.disarmReq) begin
      nextStateS = ST_DISARMED;
    end else begin
      case (stateR)
        ST_DISARMED: begin
          if (bus.armReq && !bus.delayedZone && !bus.instantZone) begin
            nextStateS = ST_EXIT_DELAY;
          end else begin
            nextStateS = ST_DISARMED;
          end
        end
        ST_EXIT_DELAY: begin
          if (expireS) begin
            nextStateS = ST_ARMED;
          end else begin
            nextStateS = ST_EXIT_DELAY;
          end
        end
        ST_ARMED: begin
          if (bus.instantZone) begin
            nextStateS = ST_ALARM;
          end else if (bus.delayedZone) begin
            nextStateS = ST_ENTRY_DELAY;
          end else begin
            nextStateS = ST_ARMED;
          end
        end
        ST_ENTRY_DELAY: begin
          if (bus.instantZone || expireS) begin
            nextStateS = ST_ALARM;
          end else begin
            nextStateS = ST_ENTRY_DELAY;
          end
        end
        ST_ALARM: begin
          if (expireS) begin
            nextStateS = ST_ARMED;
          end else begin
            nextStateS = ST_ALARM;
          end
        end
        default: nextStateS = ST_DISARMED;
      endcase
    end
  end

  // Output and counter-control logic for the state about to be entered.
  always_comb begin
    stateChangeS = (nextStateS != stateR);
    countingS    = (stateR == ST_EXIT_DELAY) || (stateR == ST_ENTRY_DELAY);
    // Every state change reloads the counter; untimed states load zero.
    loadS        = stateChangeS;
    case (nextStateS)
      ST_EXIT_DELAY:  loadValS = CNT_W'(EXIT_SEC);
      ST_ENTRY_DELAY: loadValS = CNT_W'(ENTRY_SEC);
      ST_ALARM:       loadValS = CNT_W'(SIREN_SEC);
      default:        loadValS = {CNT_W{1'b0}};
    endcase
    // Timed->timed hop drops the enable for one cycle so the upstream
    // timer restarts and the first second of the new state is full length.
    tmrENNextS = isTimed(nextStateS) && !(stateChangeS && isTimed(stateR));
    armedNextS = (nextStateS == ST_ARMED) || (nextStateS == ST_ENTRY_DELAY);
    sirenNextS = (nextStateS == ST_ALARM);
    if (stateChangeS) begin
      beepNextS = 1'b0;
    end else if (countingS && accTickS) begin
      beepNextS = ~beepR;
    end else if (countingS) begin
      beepNextS = beepR;
    end else begin
      beepNextS = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge clkSignal or posedge RST) begin
    if (RST) begin
      tmrENR <= 1'b0;
      armedR <= 1'b0;
      sirenR <= 1'b0;
      beepR  <= 1'b0;
    end else begin
      tmrENR <= tmrENNextS;
      armedR <= armedNextS;
      sirenR <= sirenNextS;
      beepR  <= beepNextS;
    end
  end

  assign bus.tmrEN    = tmrENR;
  assign bus.armed    = armedR;
  assign bus.siren    = sirenR;
  assign bus.beep     = beepR;
  assign bus.secLeft  = secCountS;
  assign bus.stateOut = stateR;

endmodule
